// File: rtl/mem_stage.sv
// Memory-access stage: branch resolve, req/ack data-memory access, registered MEM/WB fields.
// Latency 1 cycle without memop, 2+N with; stall holds upstream and inserts WB bubbles while busy.
module mem_stage #(
    parameter int DATA_W   = 64,
    parameter int MAX_WAIT = 255
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [1:0]        wb_in,
    input  logic [2:0]        m_in,
    input  logic [DATA_W-1:0] adder_out_in,
    input  logic [DATA_W-1:0] alu_result_in,
    input  logic              mux_in,
    input  logic [4:0]        rd_in,
    input  logic [DATA_W-1:0] write_data_in,
    output logic              dmem_req,
    output logic              dmem_we,
    output logic [DATA_W-1:0] dmem_addr,
    output logic [DATA_W-1:0] dmem_wdata,
    input  logic              dmem_ack,
    input  logic [DATA_W-1:0] dmem_rdata,
    output logic              pc_src,
    output logic [DATA_W-1:0] branch_target,
    output logic              stall,
    output logic              mem_err,
    output logic [1:0]        wb_out,
    output logic [DATA_W-1:0] read_data_out,
    output logic [DATA_W-1:0] alu_result_out,
    output logic [4:0]        rd_out
);

    typedef enum logic {IDLE, BUSY} state_t;

    localparam int CNT_W = $clog2(MAX_WAIT);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MAX_WAIT - 1);

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              req_q, req_d;
    logic              we_q, we_d;
    logic [DATA_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic              err_q, err_d;
    logic [1:0]        wb_q, wb_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic [DATA_W-1:0] alu_q, alu_d;
    logic [4:0]        rd_q, rd_d;
    logic              memop;
    logic              release_busy;

    assign memop         = m_in[1] | m_in[0];
    assign pc_src        = m_in[2] & mux_in;
    assign branch_target = adder_out_in;
    // Ack takes priority over a timeout landing in the same cycle.
    assign release_busy  = dmem_ack || (cnt_q == CNT_LAST);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        req_d   = req_q;
        we_d    = we_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        err_d   = 1'b0;
        wb_d    = wb_q;
        rdata_d = rdata_q;
        alu_d   = alu_q;
        rd_d    = rd_q;
        stall   = 1'b0;
        case (state_q)
            IDLE: begin
                if (memop) begin
                    stall   = 1'b1;
                    state_d = BUSY;
                    cnt_d   = '0;
                    req_d   = 1'b1;
                    we_d    = m_in[0];
                    addr_d  = alu_result_in;
                    wdata_d = write_data_in;
                    wb_d    = 2'b00;
                end else begin
                    wb_d  = wb_in;
                    alu_d = alu_result_in;
                    rd_d  = rd_in;
                end
            end
            BUSY: begin
                if (release_busy) begin
                    state_d = IDLE;
                    req_d   = 1'b0;
                    wb_d    = wb_in;
                    alu_d   = alu_result_in;
                    rd_d    = rd_in;
                    rdata_d = (dmem_ack && !we_q) ? dmem_rdata : '0;
                    err_d   = !dmem_ack;
                end else begin
                    stall = 1'b1;
                    cnt_d = cnt_q + CNT_W'(1);
                    wb_d  = 2'b00;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            req_q   <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            err_q   <= 1'b0;
            wb_q    <= 2'b00;
            rdata_q <= '0;
            alu_q   <= '0;
            rd_q    <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            req_q   <= req_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            err_q   <= err_d;
            wb_q    <= wb_d;
            rdata_q <= rdata_d;
            alu_q   <= alu_d;
            rd_q    <= rd_d;
        end
    end

    assign dmem_req       = req_q;
    assign dmem_we        = we_q;
    assign dmem_addr      = addr_q;
    assign dmem_wdata     = wdata_q;
    assign mem_err        = err_q;
    assign wb_out         = wb_q;
    assign read_data_out  = rdata_q;
    assign alu_result_out = alu_q;
    assign rd_out         = rd_q;

endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage with MAX_WAIT=4: vector table for non-memory ops,
// hand sequences for load, store, timeout, late ack and reset mid-access.
module tb_mem_stage;

    logic        clk;
    logic        rst_n;
    logic [1:0]  wb_in;
    logic [2:0]  m_in;
    logic [63:0] adder_out_in;
    logic [63:0] alu_result_in;
    logic        mux_in;
    logic [4:0]  rd_in;
    logic [63:0] write_data_in;
    logic        dmem_req;
    logic        dmem_we;
    logic [63:0] dmem_addr;
    logic [63:0] dmem_wdata;
    logic        dmem_ack;
    logic [63:0] dmem_rdata;
    logic        pc_src;
    logic [63:0] branch_target;
    logic        stall;
    logic        mem_err;
    logic [1:0]  wb_out;
    logic [63:0] read_data_out;
    logic [63:0] alu_result_out;
    logic [4:0]  rd_out;

    int checks = 0;
    int errors = 0;

    mem_stage #(.DATA_W(64), .MAX_WAIT(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .wb_in(wb_in), .m_in(m_in), .adder_out_in(adder_out_in),
        .alu_result_in(alu_result_in), .mux_in(mux_in), .rd_in(rd_in),
        .write_data_in(write_data_in),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
        .dmem_wdata(dmem_wdata), .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata),
        .pc_src(pc_src), .branch_target(branch_target), .stall(stall),
        .mem_err(mem_err), .wb_out(wb_out), .read_data_out(read_data_out),
        .alu_result_out(alu_result_out), .rd_out(rd_out)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #100000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [1:0] wb, input logic [2:0] m, input logic [63:0] alu,
                         input logic [4:0] rd, input logic [63:0] wdata);
        wb_in         = wb;
        m_in          = m;
        alu_result_in = alu;
        rd_in         = rd;
        write_data_in = wdata;
    endtask

    typedef struct {
        logic [1:0]  wb;
        logic [2:0]  m;
        logic [63:0] adder;
        logic [63:0] alu;
        logic        mux;
        logic [4:0]  rd;
        logic        exp_pc;
        logic [63:0] exp_tgt;
        logic [1:0]  exp_wb;
        logic [63:0] exp_alu;
        logic [4:0]  exp_rd;
    } vec_t;

    vec_t vecs[5];
    int   n_stall;

    initial begin
        vecs[0] = '{2'b10, 3'b000, 64'h0,   64'h2A, 1'b0, 5'd5,  1'b0, 64'h0,   2'b10, 64'h2A, 5'd5};
        vecs[1] = '{2'b00, 3'b100, 64'h400, 64'h0,  1'b1, 5'd0,  1'b1, 64'h400, 2'b00, 64'h0,  5'd0};
        vecs[2] = '{2'b00, 3'b100, 64'h400, 64'h8,  1'b0, 5'd3,  1'b0, 64'h400, 2'b00, 64'h8,  5'd3};
        vecs[3] = '{2'b10, 3'b000, 64'h7F0, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 5'd31,
                    1'b0, 64'h7F0, 2'b10, 64'hFFFF_FFFF_FFFF_FFFF, 5'd31};
        vecs[4] = '{2'b11, 3'b000, 64'h10,  64'h1234_5678_9ABC_DEF0, 1'b0, 5'd17,
                    1'b0, 64'h10,  2'b11, 64'h1234_5678_9ABC_DEF0, 5'd17};

        rst_n        = 1'b0;
        drive(2'b00, 3'b000, 64'h0, 5'd0, 64'h0);
        adder_out_in = 64'h0;
        mux_in       = 1'b0;
        dmem_ack     = 1'b0;
        dmem_rdata   = 64'h0;
        #1;
        chk("rst_req", {63'b0, dmem_req}, 64'h0);
        chk("rst_wb", {62'b0, wb_out}, 64'h0);
        chk("rst_rdata", read_data_out, 64'h0);
        chk("rst_err", {63'b0, mem_err}, 64'h0);
        chk("rst_addr", dmem_addr, 64'h0);
        @(posedge clk);
        #2 rst_n = 1'b1;

        for (int i = 0; i < 5; i++) begin
            drive(vecs[i].wb, vecs[i].m, vecs[i].alu, vecs[i].rd, 64'h0);
            adder_out_in = vecs[i].adder;
            mux_in       = vecs[i].mux;
            #1;
            chk($sformatf("v%0d_pc_src", i), {63'b0, pc_src}, {63'b0, vecs[i].exp_pc});
            chk($sformatf("v%0d_target", i), branch_target, vecs[i].exp_tgt);
            chk($sformatf("v%0d_stall", i), {63'b0, stall}, 64'h0);
            tick();
            chk($sformatf("v%0d_wb_out", i), {62'b0, wb_out}, {62'b0, vecs[i].exp_wb});
            chk($sformatf("v%0d_alu_out", i), alu_result_out, vecs[i].exp_alu);
            chk($sformatf("v%0d_rd_out", i), {59'b0, rd_out}, {59'b0, vecs[i].exp_rd});
        end
        mux_in = 1'b0;

        // Load at 0x100, ack on the third BUSY cycle.
        drive(2'b11, 3'b010, 64'h100, 5'd7, 64'h0);
        #1 chk("ld_stall_idle", {63'b0, stall}, 64'h1);
        tick();
        chk("ld_req", {63'b0, dmem_req}, 64'h1);
        chk("ld_we", {63'b0, dmem_we}, 64'h0);
        chk("ld_addr", dmem_addr, 64'h100);
        chk("ld_bubble1", {62'b0, wb_out}, 64'h0);
        chk("ld_stall_b1", {63'b0, stall}, 64'h1);
        tick();
        chk("ld_bubble2", {62'b0, wb_out}, 64'h0);
        chk("ld_stall_b2", {63'b0, stall}, 64'h1);
        chk("ld_req_hold", {63'b0, dmem_req}, 64'h1);
        tick();
        dmem_ack   = 1'b1;
        dmem_rdata = 64'hDEADBEEF;
        #1 chk("ld_stall_ack", {63'b0, stall}, 64'h0);
        tick();
        dmem_ack = 1'b0;
        drive(2'b00, 3'b000, 64'h0, 5'd0, 64'h0);
        chk("ld_rdata", read_data_out, 64'hDEADBEEF);
        chk("ld_wb", {62'b0, wb_out}, 64'h3);
        chk("ld_rd", {59'b0, rd_out}, 64'd7);
        chk("ld_req_drop", {63'b0, dmem_req}, 64'h0);

        // Store with both mem bits set is a store; ack in first BUSY cycle.
        drive(2'b00, 3'b011, 64'h80, 5'd0, 64'h55);
        #1 chk("st_stall_idle", {63'b0, stall}, 64'h1);
        tick();
        chk("st_we", {63'b0, dmem_we}, 64'h1);
        chk("st_addr", dmem_addr, 64'h80);
        chk("st_wdata", dmem_wdata, 64'h55);
        dmem_ack   = 1'b1;
        dmem_rdata = 64'hFFFF;
        #1 chk("st_stall_ack", {63'b0, stall}, 64'h0);
        tick();
        dmem_ack = 1'b0;
        drive(2'b00, 3'b000, 64'h0, 5'd0, 64'h0);
        chk("st_rdata_zero", read_data_out, 64'h0);
        chk("st_req_drop", {63'b0, dmem_req}, 64'h0);

        // Quick load leaves nonzero read data ahead of the timeout.
        drive(2'b11, 3'b010, 64'h40, 5'd9, 64'h0);
        tick();
        dmem_ack   = 1'b1;
        dmem_rdata = 64'h1234;
        tick();
        dmem_ack = 1'b0;
        drive(2'b00, 3'b000, 64'h0, 5'd0, 64'h0);
        chk("ld2_rdata", read_data_out, 64'h1234);

        // Timeout: no ack at all.
        drive(2'b11, 3'b010, 64'h200, 5'd4, 64'h0);
        n_stall = 0;
        #1;
        while (stall && n_stall < 20) begin
            n_stall++;
            tick();
        end
        chk("to_stall_cycles", 64'(n_stall), 64'd4);
        chk("to_err_early", {63'b0, mem_err}, 64'h0);
        tick();
        drive(2'b00, 3'b000, 64'h0, 5'd0, 64'h0);
        chk("to_err_pulse", {63'b0, mem_err}, 64'h1);
        chk("to_rdata_zero", read_data_out, 64'h0);
        chk("to_req_drop", {63'b0, dmem_req}, 64'h0);
        chk("to_wb", {62'b0, wb_out}, 64'h3);
        tick();
        chk("to_err_clear", {63'b0, mem_err}, 64'h0);
        dmem_ack   = 1'b1;
        dmem_rdata = 64'hBAD;
        #1 chk("late_ack_stall", {63'b0, stall}, 64'h0);
        tick();
        dmem_ack = 1'b0;
        chk("late_ack_rdata", read_data_out, 64'h0);
        chk("late_ack_err", {63'b0, mem_err}, 64'h0);

        // Reset while an access is outstanding.
        drive(2'b11, 3'b010, 64'h300, 5'd6, 64'h0);
        tick();
        chk("rb_req_up", {63'b0, dmem_req}, 64'h1);
        #1 rst_n = 1'b0;
        drive(2'b10, 3'b000, 64'h99, 5'd2, 64'h0);
        #1;
        chk("rb_req", {63'b0, dmem_req}, 64'h0);
        chk("rb_wb", {62'b0, wb_out}, 64'h0);
        chk("rb_err", {63'b0, mem_err}, 64'h0);
        #2 rst_n = 1'b1;
        #1 chk("rb_idle_stall", {63'b0, stall}, 64'h0);
        tick();
        chk("rb_nop_alu", alu_result_out, 64'h99);
        chk("rb_nop_wb", {62'b0, wb_out}, 64'h2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
